// File: rtl/komandara_axi4_burst_master.sv
// Command-driven AXI4 master: one request becomes one INCR burst; one transaction in flight.
// Optional 4 KiB boundary rejection is enabled by defining KOMANDARA_AXI4_MST_4K_CHECK_EN.
module komandara_axi4_burst_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [7:0]              cmd_len_i,
  input  logic [ID_WIDTH-1:0]     cmd_id_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_last_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic                    done_o,
  output logic [1:0]              done_resp_o,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] AX_SIZE = 3'(OFFS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFFS) - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [1:0]            resp_acc_q, resp_acc_d;
  logic                  awvalid_q, awvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
  logic                  unused_ids;

  // Response IDs are not checked: only one transaction is ever outstanding.
  assign unused_ids       = ^{m_axi_bid, m_axi_rid};
  assign cmd_addr_aligned = cmd_addr_i & ALIGN_MASK;

`ifdef KOMANDARA_AXI4_MST_4K_CHECK_EN
  logic [16:0] span_end;
  logic        crosses_4k;
  assign span_end   = 17'(cmd_addr_aligned[11:0]) + ((17'(cmd_len_i) + 17'd1) << OFFS);
  assign crosses_4k = span_end > 17'd4096;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    beat_cnt_d  = beat_cnt_q;
    resp_acc_d  = resp_acc_q;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    m_axi_wvalid = 1'b0;
    m_axi_wlast  = 1'b0;
    m_axi_bready = 1'b0;
    rd_valid_o   = 1'b0;
    m_axi_rready = 1'b0;
    done_o       = 1'b0;
    done_resp_o  = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d     = cmd_addr_aligned;
          len_d      = cmd_len_i;
          id_d       = cmd_id_i;
          beat_cnt_d = cmd_len_i;
          resp_acc_d = 2'b00;
`ifdef KOMANDARA_AXI4_MST_4K_CHECK_EN
          if (crosses_4k) begin
            state_d    = S_DONE;
            resp_acc_d = 2'b10;
          end else
`endif
          begin
            state_d = cmd_write_i ? S_AW : S_AR;
          end
        end
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_W: begin
        m_axi_wvalid = wr_valid_i;
        wr_ready_o   = m_axi_wready;
        m_axi_wlast  = (beat_cnt_q == 8'd0);
        if (wr_valid_i && m_axi_wready) begin
          beat_cnt_d = beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd0) state_d = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          resp_acc_d = m_axi_bresp;
          state_d    = S_DONE;
        end
      end
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R: begin
        rd_valid_o   = m_axi_rvalid;
        m_axi_rready = rd_ready_i;
        // Numeric max ranks DECERR > SLVERR > EXOKAY > OKAY; the slave's rlast ends the burst.
        if (m_axi_rvalid && rd_ready_i) begin
          if (m_axi_rresp > resp_acc_q) resp_acc_d = m_axi_rresp;
          if (m_axi_rlast) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        done_resp_o = resp_acc_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign awvalid_d = (state_d == S_AW);
  assign arvalid_d = (state_d == S_AR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
      resp_acc_q <= '0;
      awvalid_q  <= 1'b0;
      arvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      id_q       <= id_d;
      beat_cnt_q <= beat_cnt_d;
      resp_acc_q <= resp_acc_d;
      awvalid_q  <= awvalid_d;
      arvalid_q  <= arvalid_d;
    end
  end

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AX_SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = AX_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_wdata   = wr_data_i;
  assign m_axi_wstrb   = wr_strb_i;
  assign rd_data_o     = m_axi_rdata;
  assign rd_last_o     = m_axi_rlast;

endmodule
